// File: rtl/xalu_pkg.sv
// rtl/xalu_pkg.sv - shared op encodings, FSM states and result type for the HI/LO multiply/divide sequencer
package xalu_pkg;

   localparam logic [2:0] XALU_MULT  = 3'd0;
   localparam logic [2:0] XALU_MULTU = 3'd1;
   localparam logic [2:0] XALU_DIV   = 3'd2;
   localparam logic [2:0] XALU_DIVU  = 3'd3;
   localparam logic [2:0] XALU_MTHI  = 3'd4;
   localparam logic [2:0] XALU_MTLO  = 3'd5;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } xalu_state_e;

   typedef logic [63:0] xalu_res_t;

   // MULT/MULTU/DIV/DIVU occupy the lower half of the encoding space.
   function automatic logic op_is_calc(input logic [2:0] op);
      return !op[2];
   endfunction

   function automatic logic op_is_div(input logic [2:0] op);
      return (op == XALU_DIV) || (op == XALU_DIVU);
   endfunction

endpackage

// File: rtl/xalu_calc.sv
// rtl/xalu_calc.sv - combinational product/quotient/remainder for MULT, MULTU, DIV and DIVU
module xalu_calc
   import xalu_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        div_by_zero
);

   xalu_res_t   prod_s;
   xalu_res_t   prod_u;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] div_b;
   logic [31:0] quo_u;
   logic [31:0] rem_u;
   logic        signed_div;

   always_comb begin
      signed_div = (op == XALU_DIV);
      prod_s     = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      prod_u     = {32'd0, a} * {32'd0, b};
      // Signed divide works on magnitudes, then restores signs: quotient
      // truncates toward zero and the remainder follows the dividend.
      mag_a      = (signed_div && a[31]) ? -a : a;
      mag_b      = (signed_div && b[31]) ? -b : b;
      div_b      = (b == 32'd0) ? 32'd1 : mag_b;
      quo_u      = mag_a / div_b;
      rem_u      = mag_a % div_b;

      res_hi      = 32'd0;
      res_lo      = 32'd0;
      div_by_zero = 1'b0;
      case (op)
         XALU_MULT: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         XALU_MULTU: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         XALU_DIV: begin
            res_lo      = (a[31] ^ b[31]) ? -quo_u : quo_u;
            res_hi      = a[31] ? -rem_u : rem_u;
            div_by_zero = (b == 32'd0);
         end
         XALU_DIVU: begin
            res_lo      = quo_u;
            res_hi      = rem_u;
            div_by_zero = (b == 32'd0);
         end
         default: begin
            res_hi      = 32'd0;
            res_lo      = 32'd0;
            div_by_zero = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/xalu_sequencer.sv
// rtl/xalu_sequencer.sv - multi-cycle HI/LO mult/div sequencer for the E stage
// Optional flush input enabled by defining XALU_CANCEL_EN.
module xalu_sequencer
   import xalu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
`ifdef XALU_CANCEL_EN
   input  logic        cancel,
`endif
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

   xalu_state_e      state;
   xalu_state_e      state_next;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      pend_hi;
   logic [31:0]      pend_lo;
   logic             pend_dz;
   logic [31:0]      res_hi;
   logic [31:0]      res_lo;
   logic             div_by_zero;
   logic             kill;
   logic             accept;
   logic             wr_hi;
   logic             wr_lo;
   logic             commit;
   logic             done_next;

`ifdef XALU_CANCEL_EN
   assign kill = cancel;
`else
   assign kill = 1'b0;
`endif

   xalu_calc u_calc (
      .op          (op),
      .a           (a),
      .b           (b),
      .res_hi      (res_hi),
      .res_lo      (res_lo),
      .div_by_zero (div_by_zero)
   );

   assign busy = (state == S_RUN);

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      wr_hi      = 1'b0;
      wr_lo      = 1'b0;
      commit     = 1'b0;
      done_next  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && !kill) begin
               if (op_is_calc(op)) begin
                  accept     = 1'b1;
                  state_next = S_RUN;
               end else if (op == XALU_MTHI) begin
                  wr_hi     = 1'b1;
                  done_next = 1'b1;
               end else if (op == XALU_MTLO) begin
                  wr_lo     = 1'b1;
                  done_next = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (kill) begin
               state_next = S_IDLE;
            end else if (cnt == '0) begin
               commit     = 1'b1;
               done_next  = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_dz <= 1'b0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         done    <= 1'b0;
      end else begin
         state <= state_next;
         done  <= done_next;
         if (accept) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_dz <= div_by_zero;
            cnt     <= op_is_div(op) ? DIV_LOAD : MUL_LOAD;
         end else if (busy && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (wr_hi) hi <= a;
         if (wr_lo) lo <= a;
         // Divide-by-zero still spends the full latency but leaves HI/LO alone.
         if (commit && !pend_dz) begin
            hi <= pend_hi;
            lo <= pend_lo;
         end
      end
   end

endmodule

// File: tb/tb_xalu_sequencer.sv
// tb/tb_xalu_sequencer.sv - directed self-checking bench for xalu_sequencer (XALU_CANCEL_EN optional)
module tb_xalu_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        busy, done, busy1, done1;
   logic [31:0] hi, lo, hi1, lo1;
`ifdef XALU_CANCEL_EN
   logic        cancel = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   xalu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset),
`ifdef XALU_CANCEL_EN
      .cancel(cancel),
`endif
      .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   xalu_sequencer #(.MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset),
`ifdef XALU_CANCEL_EN
      .cancel(cancel),
`endif
      .start(start), .op(op), .a(a), .b(b),
      .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      tick();
      start = 1'b0;
   endtask

   // Counts busy samples (first one is the sample right after the start edge)
   // and done pulses until busy drops; cycles = -1 on timeout.
   task automatic wait_idle(output int cycles, output int dn);
      cycles = 0;
      dn     = 0;
      while (busy === 1'b1 && cycles < 40) begin
         cycles++;
         tick();
         if (done === 1'b1) dn++;
      end
      if (busy === 1'b1) cycles = -1;
   endtask

   task automatic test_reset();
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
      n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
      n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_mult();
      int c, d;
      issue(3'd0, 32'hFFFF_FFFE, 32'd3);
      wait_idle(c, d);
      n_checks++; if (c !== 5) begin n_fail++; $display("FAIL mult_busy_cycles got %0d want 5", c); end
      n_checks++; if (d !== 1) begin n_fail++; $display("FAIL mult_done_pulses got %0d want 1", d); end
      n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", hi); end
      n_checks++; if (lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_lo got %h want fffffffa", lo); end
      tick();
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_width got %0b want 0", done); end
   endtask

   task automatic test_multu();
      int c, d;
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle(c, d);
      n_checks++; if (c !== 5) begin n_fail++; $display("FAIL multu_busy_cycles got %0d want 5", c); end
      n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi got %h want fffffffe", hi); end
      n_checks++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo got %h want 00000001", lo); end
      tick();
   endtask

   task automatic test_div();
      int c, d;
      issue(3'd2, 32'hFFFF_FFF9, 32'd2);
      wait_idle(c, d);
      n_checks++; if (c !== 10) begin n_fail++; $display("FAIL div_busy_cycles got %0d want 10", c); end
      n_checks++; if (d !== 1) begin n_fail++; $display("FAIL div_done_pulses got %0d want 1", d); end
      n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", lo); end
      n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", hi); end
      tick();
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(c, d);
      n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
      n_checks++; if (hi !== 32'h0000_0000) begin n_fail++; $display("FAIL div_ovf_hi got %h want 00000000", hi); end
      tick();
   endtask

   task automatic test_div_by_zero();
      int c, d;
      issue(3'd4, 32'h12, 32'd0);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy got %0b want 0", busy); end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mthi_done got %0b want 1", done); end
      n_checks++; if (hi !== 32'h12) begin n_fail++; $display("FAIL mthi_hi got %h want 00000012", hi); end
      issue(3'd5, 32'h34, 32'd0);
      n_checks++; if (lo !== 32'h34) begin n_fail++; $display("FAIL mtlo_lo got %h want 00000034", lo); end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mtlo_done got %0b want 1", done); end
      tick();
      issue(3'd3, 32'd100, 32'd0);
      wait_idle(c, d);
      n_checks++; if (c !== 10) begin n_fail++; $display("FAIL divz_busy_cycles got %0d want 10", c); end
      n_checks++; if (d !== 1) begin n_fail++; $display("FAIL divz_done_pulses got %0d want 1", d); end
      n_checks++; if (hi !== 32'h12) begin n_fail++; $display("FAIL divz_hi got %h want 00000012", hi); end
      n_checks++; if (lo !== 32'h34) begin n_fail++; $display("FAIL divz_lo got %h want 00000034", lo); end
      tick();
   endtask

   task automatic test_reset_mid_run();
      issue(3'd0, 32'd2, 32'd2);
      tick();
      tick();
      reset = 1'b1;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %0b want 0", busy); end
      n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL rst_mid_hi got %h want 0", hi); end
      n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL rst_mid_lo got %h want 0", lo); end
      tick();
      reset = 1'b0;
      tick();
      issue(3'd5, 32'h55, 32'd0);
      n_checks++; if (lo !== 32'h55) begin n_fail++; $display("FAIL rst_mtlo_lo got %h want 00000055", lo); end
      n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL rst_mtlo_hi got %h want 0", hi); end
      tick();
   endtask

   task automatic test_start_while_run();
      int c, d;
      issue(3'd0, 32'd2, 32'd2);
      tick();
      issue(3'd3, 32'd100, 32'd7);
      n_checks++; if (hi !== 32'd0 || lo !== 32'h55) begin n_fail++; $display("FAIL swr_unchanged got hi=%h lo=%h want hi=0 lo=55", hi, lo); end
      wait_idle(c, d);
      n_checks++; if (c !== 3) begin n_fail++; $display("FAIL swr_busy_tail got %0d want 3", c); end
      n_checks++; if (lo !== 32'd4) begin n_fail++; $display("FAIL swr_lo got %h want 00000004", lo); end
      n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL swr_hi got %h want 0", hi); end
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL swr_no_requeue got %0b want 0", busy); end
   endtask

   task automatic test_ignored_op();
      issue(3'd6, 32'hDEAD_BEEF, 32'd1);
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL nop_flags got busy=%0b done=%0b want 0 0", busy, done); end
      issue(3'd7, 32'hDEAD_BEEF, 32'd1);
      n_checks++; if (hi !== 32'd0 || lo !== 32'd4) begin n_fail++; $display("FAIL nop_regs got hi=%h lo=%h want 0 4", hi, lo); end
   endtask

   task automatic test_latency_one();
      int c, d;
      issue(3'd1, 32'd3, 32'd4);
      n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL lat1_busy got %0b want 1", busy1); end
      tick();
      n_checks++; if (busy1 !== 1'b0 || done1 !== 1'b1) begin n_fail++; $display("FAIL lat1_end got busy=%0b done=%0b want 0 1", busy1, done1); end
      n_checks++; if (lo1 !== 32'd12 || hi1 !== 32'd0) begin n_fail++; $display("FAIL lat1_result got hi=%h lo=%h want 0 c", hi1, lo1); end
      wait_idle(c, d);
      tick();
   endtask

   task automatic test_back_to_back();
      int c, d;
      issue(3'd3, 32'd100, 32'd7);
      wait_idle(c, d);
      n_checks++; if (lo !== 32'd14 || hi !== 32'd2) begin n_fail++; $display("FAIL b2b_divu got hi=%h lo=%h want 2 e", hi, lo); end
      issue(3'd1, 32'h0001_0000, 32'h0001_0000);
      n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_restart got busy=%0b done=%0b want 1 0", busy, done); end
      wait_idle(c, d);
      n_checks++; if (c !== 5) begin n_fail++; $display("FAIL b2b_busy_cycles got %0d want 5", c); end
      n_checks++; if (hi !== 32'd1 || lo !== 32'd0) begin n_fail++; $display("FAIL b2b_multu got hi=%h lo=%h want 1 0", hi, lo); end
      tick();
   endtask

`ifdef XALU_CANCEL_EN
   task automatic test_cancel();
      int c, d;
      issue(3'd0, 32'd5, 32'd5);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy got %0b want 0", busy); end
      tick();
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL cancel_done got %0b want 0", done); end
      n_checks++; if (hi !== 32'd1 || lo !== 32'd0) begin n_fail++; $display("FAIL cancel_regs got hi=%h lo=%h want 1 0", hi, lo); end
      cancel = 1'b1;
      issue(3'd5, 32'h77, 32'd0);
      cancel = 1'b0;
      n_checks++; if (lo !== 32'd0 || done !== 1'b0) begin n_fail++; $display("FAIL cancel_mtlo got lo=%h done=%0b want 0 0", lo, done); end
      wait_idle(c, d);
   endtask
`endif

   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_div_by_zero();
      test_reset_mid_run();
      test_start_while_run();
      test_ignored_op();
      test_latency_one();
      test_back_to_back();
`ifdef XALU_CANCEL_EN
      test_cancel();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
